// File: rtl/hazard_stall_ctrl.sv
// Load-use stall / branch flush / memory freeze controller for a 5-stage pipeline.
// Drives per-stage enables and bubble controls, and keeps saturating event counters.
module hazard_stall_ctrl #(
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic [4:0]       EX_RD,
  input  logic [2:0]       EX_MEM_READ,
  input  logic             EX_REG_WRITE,
  input  logic             BRANCH_TAKEN,
  input  logic             DMEM_BUSY,
  input  logic             IMEM_BUSY,
  output logic             PC_EN,
  output logic             IFID_EN,
  output logic             IFID_FLUSH,
  output logic             IDEX_EN,
  output logic             IDEX_BUBBLE,
  output logic             EXMEM_EN,
  output logic             MEMWB_EN,
  output logic             STATE,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic [CNT_W-1:0] FLUSH_COUNT,
  output logic [CNT_W-1:0] FREEZE_COUNT
);

  typedef enum logic {RUN = 1'b0, LOAD_STALL = 1'b1} state_t;

  localparam logic [1:0] REM_INIT = 2'(LOAD_LATENCY - 1);

  state_t                     state_q, state_d;
  logic [1:0]                 rem_q, rem_d;
  logic                       haz;
  // index 0 = stall, 1 = flush, 2 = freeze
  logic [2:0]                 inc;
  logic [2:0][CNT_W-1:0]      cnt_q;

  assign haz = (EX_MEM_READ != 3'd0) && EX_REG_WRITE && (EX_RD != 5'd0) &&
               ((ID_USES_RS1 && (ID_RS1 == EX_RD)) || (ID_USES_RS2 && (ID_RS2 == EX_RD)));

  always_comb begin
    PC_EN       = 1'b1;
    IFID_EN     = 1'b1;
    IFID_FLUSH  = 1'b0;
    IDEX_EN     = 1'b1;
    IDEX_BUBBLE = 1'b0;
    EXMEM_EN    = 1'b1;
    MEMWB_EN    = 1'b1;
    state_d     = state_q;
    rem_d       = rem_q;
    inc         = 3'b000;
    if (!RESET) begin
      PC_EN       = 1'b0;
      IFID_EN     = 1'b0;
      IFID_FLUSH  = 1'b1;
      IDEX_EN     = 1'b0;
      IDEX_BUBBLE = 1'b1;
      EXMEM_EN    = 1'b0;
      MEMWB_EN    = 1'b0;
      state_d     = RUN;
      rem_d       = 2'd0;
    end else if (DMEM_BUSY) begin
      PC_EN    = 1'b0;
      IFID_EN  = 1'b0;
      IDEX_EN  = 1'b0;
      EXMEM_EN = 1'b0;
      MEMWB_EN = 1'b0;
      inc[2]   = 1'b1;
    end else if (BRANCH_TAKEN) begin
      // wrong-path instructions in IF/ID and ID become NOPs; pending load bubbles are moot
      IFID_FLUSH  = 1'b1;
      IDEX_BUBBLE = 1'b1;
      state_d     = RUN;
      rem_d       = 2'd0;
      inc[1]      = 1'b1;
    end else if ((state_q == RUN && haz) || state_q == LOAD_STALL) begin
      PC_EN       = 1'b0;
      IFID_EN     = 1'b0;
      IDEX_BUBBLE = 1'b1;
      inc[0]      = 1'b1;
      if (state_q == RUN) begin
        if (LOAD_LATENCY > 1) begin
          state_d = LOAD_STALL;
          rem_d   = REM_INIT;
        end
      end else if (rem_q == 2'd1) begin
        state_d = RUN;
        rem_d   = 2'd0;
      end else begin
        rem_d = rem_q - 2'd1;
      end
    end else if (IMEM_BUSY) begin
      PC_EN      = 1'b0;
      IFID_FLUSH = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= RUN;
      rem_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      for (int i = 0; i < 3; i++)
        if (inc[i] && (cnt_q[i] != {CNT_W{1'b1}}))
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  assign STATE        = (state_q == LOAD_STALL);
  assign STALL_COUNT  = cnt_q[0];
  assign FLUSH_COUNT  = cnt_q[1];
  assign FREEZE_COUNT = cnt_q[2];

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: three instances (latency 1, latency 3, 4-bit counters)
// share one stimulus stream; per-cycle expectations flow through a scoreboard queue.
module tb_hazard_stall_ctrl;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] ID_RS1, ID_RS2, EX_RD;
  logic       ID_USES_RS1, ID_USES_RS2, EX_REG_WRITE;
  logic [2:0] EX_MEM_READ;
  logic       BRANCH_TAKEN, DMEM_BUSY, IMEM_BUSY;

  logic        pc_1, ifen_1, iffl_1, iden_1, idbb_1, exen_1, mwen_1, st_1;
  logic        pc_3, ifen_3, iffl_3, iden_3, idbb_3, exen_3, mwen_3, st_3;
  logic        pc_s, ifen_s, iffl_s, iden_s, idbb_s, exen_s, mwen_s, st_s;
  logic [15:0] stall_1, flush_1, frz_1, stall_3, flush_3, frz_3;
  logic [3:0]  stall_s, flush_s, frz_s;
  logic [6:0]  ctl_1, ctl_3;

  int n_chk  = 0;
  int n_fail = 0;

  // {PC_EN, IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_BUBBLE, EXMEM_EN, MEMWB_EN}
  localparam logic [6:0] C_RUN = 7'b1101011, C_RST = 7'b0010100, C_STL = 7'b0001111,
                         C_FRZ = 7'b0000000, C_BR  = 7'b1111111, C_IMB = 7'b0111011;

  typedef struct {
    logic rn, haz, x0, br, db, ib;
    logic [6:0] e1; logic s1;
    logic [6:0] e3; logic s3;
  } vec_t;
  vec_t sb[$];
  vec_t v;

  always #5 CLK = ~CLK;

  assign ctl_1 = {pc_1, ifen_1, iffl_1, iden_1, idbb_1, exen_1, mwen_1};
  assign ctl_3 = {pc_3, ifen_3, iffl_3, iden_3, idbb_3, exen_3, mwen_3};

  hazard_stall_ctrl #(.LOAD_LATENCY(1), .CNT_W(16)) dut1 (
    .CLK(CLK), .RESET(RESET), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1),
    .ID_USES_RS2(ID_USES_RS2), .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ),
    .EX_REG_WRITE(EX_REG_WRITE), .BRANCH_TAKEN(BRANCH_TAKEN), .DMEM_BUSY(DMEM_BUSY),
    .IMEM_BUSY(IMEM_BUSY), .PC_EN(pc_1), .IFID_EN(ifen_1), .IFID_FLUSH(iffl_1),
    .IDEX_EN(iden_1), .IDEX_BUBBLE(idbb_1), .EXMEM_EN(exen_1), .MEMWB_EN(mwen_1),
    .STATE(st_1), .STALL_COUNT(stall_1), .FLUSH_COUNT(flush_1), .FREEZE_COUNT(frz_1));

  hazard_stall_ctrl #(.LOAD_LATENCY(3), .CNT_W(16)) dut3 (
    .CLK(CLK), .RESET(RESET), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1),
    .ID_USES_RS2(ID_USES_RS2), .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ),
    .EX_REG_WRITE(EX_REG_WRITE), .BRANCH_TAKEN(BRANCH_TAKEN), .DMEM_BUSY(DMEM_BUSY),
    .IMEM_BUSY(IMEM_BUSY), .PC_EN(pc_3), .IFID_EN(ifen_3), .IFID_FLUSH(iffl_3),
    .IDEX_EN(iden_3), .IDEX_BUBBLE(idbb_3), .EXMEM_EN(exen_3), .MEMWB_EN(mwen_3),
    .STATE(st_3), .STALL_COUNT(stall_3), .FLUSH_COUNT(flush_3), .FREEZE_COUNT(frz_3));

  hazard_stall_ctrl #(.LOAD_LATENCY(1), .CNT_W(4)) dut_s (
    .CLK(CLK), .RESET(RESET), .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_USES_RS1(ID_USES_RS1),
    .ID_USES_RS2(ID_USES_RS2), .EX_RD(EX_RD), .EX_MEM_READ(EX_MEM_READ),
    .EX_REG_WRITE(EX_REG_WRITE), .BRANCH_TAKEN(BRANCH_TAKEN), .DMEM_BUSY(DMEM_BUSY),
    .IMEM_BUSY(IMEM_BUSY), .PC_EN(pc_s), .IFID_EN(ifen_s), .IFID_FLUSH(iffl_s),
    .IDEX_EN(iden_s), .IDEX_BUBBLE(idbb_s), .EXMEM_EN(exen_s), .MEMWB_EN(mwen_s),
    .STATE(st_s), .STALL_COUNT(stall_s), .FLUSH_COUNT(flush_s), .FREEZE_COUNT(frz_s));

  task automatic add(input logic rn, haz, x0, br, db, ib,
                     input logic [6:0] e1, input logic s1, input logic [6:0] e3, input logic s3);
    vec_t t;
    t.rn = rn; t.haz = haz; t.x0 = x0; t.br = br; t.db = db; t.ib = ib;
    t.e1 = e1; t.s1 = s1; t.e3 = e3; t.s3 = s3;
    sb.push_back(t);
  endtask

  // haz: load into x5 consumed via RS2; x0: same pattern targeting x0; else a non-load writer
  task automatic apply(input vec_t t);
    RESET        = t.rn;
    ID_RS1       = 5'd7;
    ID_USES_RS1  = 1'b1;
    ID_RS2       = t.x0 ? 5'd0 : 5'd5;
    ID_USES_RS2  = 1'b1;
    EX_RD        = t.x0 ? 5'd0 : 5'd5;
    EX_MEM_READ  = (t.haz || t.x0) ? 3'b010 : 3'b000;
    EX_REG_WRITE = 1'b1;
    BRANCH_TAKEN = t.br;
    DMEM_BUSY    = t.db;
    IMEM_BUSY    = t.ib;
  endtask

  task automatic test_reset();
    add(0,0,0,0,0,0, C_RST,0, C_RST,0);
    add(0,0,0,0,0,0, C_RST,0, C_RST,0);
    add(1,0,0,0,0,0, C_RUN,0, C_RUN,0);
    while (sb.size() > 0) begin
      v = sb.pop_front(); apply(v); @(negedge CLK);
      n_chk += 2;
      if ({ctl_1, st_1} !== {v.e1, v.s1}) begin n_fail++;
        $display("FAIL reset ctl dut1: got %b/%b want %b/%b", ctl_1, st_1, v.e1, v.s1); end
      if ({ctl_3, st_3} !== {v.e3, v.s3}) begin n_fail++;
        $display("FAIL reset ctl dut3: got %b/%b want %b/%b", ctl_3, st_3, v.e3, v.s3); end
      if (v.rn) begin
        n_chk++;
        if ({stall_1, flush_1, frz_1, stall_3, flush_3, frz_3, stall_s, flush_s, frz_s} !== '0) begin
          n_fail++; $display("FAIL reset counters: got %h want 0",
            {stall_1, flush_1, frz_1, stall_3, flush_3, frz_3, stall_s, flush_s, frz_s}); end
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_load_use();
    add(1,1,0,0,0,0, C_STL,0, C_STL,0);
    add(1,0,0,0,0,0, C_RUN,0, C_STL,1);
    add(1,0,0,0,0,0, C_RUN,0, C_STL,1);
    add(1,0,0,0,0,0, C_RUN,0, C_RUN,0);
    add(1,0,1,0,0,0, C_RUN,0, C_RUN,0);
    add(1,0,0,0,0,0, C_RUN,0, C_RUN,0);
    while (sb.size() > 0) begin
      v = sb.pop_front(); apply(v); @(negedge CLK);
      n_chk += 2;
      if ({ctl_1, st_1} !== {v.e1, v.s1}) begin n_fail++;
        $display("FAIL load_use ctl dut1: got %b/%b want %b/%b", ctl_1, st_1, v.e1, v.s1); end
      if ({ctl_3, st_3} !== {v.e3, v.s3}) begin n_fail++;
        $display("FAIL load_use ctl dut3: got %b/%b want %b/%b", ctl_3, st_3, v.e3, v.s3); end
      @(posedge CLK); #1;
    end
    n_chk += 2;
    if (stall_1 !== 16'd1) begin n_fail++; $display("FAIL load_use stall dut1: got %0d want 1", stall_1); end
    if (stall_3 !== 16'd3) begin n_fail++; $display("FAIL load_use stall dut3: got %0d want 3", stall_3); end
  endtask

  task automatic test_freeze();
    add(1,1,0,0,0,0, C_STL,0, C_STL,0);
    for (int i = 0; i < 4; i++) add(1,0,0,0,1,0, C_FRZ,0, C_FRZ,1);
    add(1,0,0,0,0,0, C_RUN,0, C_STL,1);
    add(1,0,0,0,0,0, C_RUN,0, C_STL,1);
    add(1,0,0,0,0,0, C_RUN,0, C_RUN,0);
    while (sb.size() > 0) begin
      v = sb.pop_front(); apply(v); @(negedge CLK);
      n_chk += 2;
      if ({ctl_1, st_1} !== {v.e1, v.s1}) begin n_fail++;
        $display("FAIL freeze ctl dut1: got %b/%b want %b/%b", ctl_1, st_1, v.e1, v.s1); end
      if ({ctl_3, st_3} !== {v.e3, v.s3}) begin n_fail++;
        $display("FAIL freeze ctl dut3: got %b/%b want %b/%b", ctl_3, st_3, v.e3, v.s3); end
      @(posedge CLK); #1;
    end
    n_chk += 2;
    if ({stall_1, frz_1} !== {16'd2, 16'd4}) begin n_fail++;
      $display("FAIL freeze counts dut1: got %0d/%0d want 2/4", stall_1, frz_1); end
    if ({stall_3, frz_3} !== {16'd6, 16'd4}) begin n_fail++;
      $display("FAIL freeze counts dut3: got %0d/%0d want 6/4", stall_3, frz_3); end
  endtask

  task automatic test_precedence();
    add(1,1,0,1,0,1, C_BR,0,  C_BR,0);
    add(1,0,0,0,0,1, C_IMB,0, C_IMB,0);
    add(1,0,0,0,0,0, C_RUN,0, C_RUN,0);
    add(1,1,0,0,0,0, C_STL,0, C_STL,0);
    add(1,0,0,1,0,0, C_BR,0,  C_BR,1);
    add(1,0,0,0,0,0, C_RUN,0, C_RUN,0);
    while (sb.size() > 0) begin
      v = sb.pop_front(); apply(v); @(negedge CLK);
      n_chk += 2;
      if ({ctl_1, st_1} !== {v.e1, v.s1}) begin n_fail++;
        $display("FAIL precedence ctl dut1: got %b/%b want %b/%b", ctl_1, st_1, v.e1, v.s1); end
      if ({ctl_3, st_3} !== {v.e3, v.s3}) begin n_fail++;
        $display("FAIL precedence ctl dut3: got %b/%b want %b/%b", ctl_3, st_3, v.e3, v.s3); end
      @(posedge CLK); #1;
    end
    n_chk += 2;
    if ({stall_1, flush_1} !== {16'd3, 16'd2}) begin n_fail++;
      $display("FAIL precedence counts dut1: got %0d/%0d want 3/2", stall_1, flush_1); end
    if ({stall_3, flush_3} !== {16'd7, 16'd2}) begin n_fail++;
      $display("FAIL precedence counts dut3: got %0d/%0d want 7/2", stall_3, flush_3); end
  endtask

  task automatic test_saturation();
    int exp_s = 2;
    for (int i = 0; i < 20; i++) add(1,0,0,1,0,0, C_BR,0, C_BR,0);
    while (sb.size() > 0) begin
      v = sb.pop_front(); apply(v); @(negedge CLK);
      n_chk++;
      if ({ctl_1, st_1} !== {v.e1, v.s1}) begin n_fail++;
        $display("FAIL saturation ctl dut1: got %b/%b want %b/%b", ctl_1, st_1, v.e1, v.s1); end
      @(posedge CLK); #1;
      if (exp_s < 15) exp_s++;
      n_chk++;
      if (flush_s !== 4'(exp_s)) begin n_fail++;
        $display("FAIL saturation flush dut_s: got %0d want %0d", flush_s, exp_s); end
    end
    n_chk += 2;
    if (flush_1 !== 16'd22) begin n_fail++; $display("FAIL saturation flush dut1: got %0d want 22", flush_1); end
    if ({stall_s, frz_s} !== {4'd3, 4'd4}) begin n_fail++;
      $display("FAIL saturation other dut_s: got %0d/%0d want 3/4", stall_s, frz_s); end
  endtask

  task automatic test_reset_mid_stall();
    add(1,1,0,0,0,0, C_STL,0, C_STL,0);
    add(0,1,0,0,0,0, C_RST,0, C_RST,1);
    add(1,0,0,0,0,0, C_RUN,0, C_RUN,0);
    while (sb.size() > 0) begin
      v = sb.pop_front(); apply(v); @(negedge CLK);
      n_chk += 2;
      if ({ctl_1, st_1} !== {v.e1, v.s1}) begin n_fail++;
        $display("FAIL mid_reset ctl dut1: got %b/%b want %b/%b", ctl_1, st_1, v.e1, v.s1); end
      if ({ctl_3, st_3} !== {v.e3, v.s3}) begin n_fail++;
        $display("FAIL mid_reset ctl dut3: got %b/%b want %b/%b", ctl_3, st_3, v.e3, v.s3); end
      @(posedge CLK); #1;
    end
    n_chk++;
    if ({stall_1, flush_1, frz_1, stall_3, flush_3, frz_3, stall_s, flush_s, frz_s} !== '0) begin
      n_fail++; $display("FAIL mid_reset counters: got %h want 0",
        {stall_1, flush_1, frz_1, stall_3, flush_3, frz_3, stall_s, flush_s, frz_s}); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_freeze();
    test_precedence();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/flush controller on the consumer side of the ID/EX pipeline register.
- Compares ID-stage source registers against the EX-stage destination and load-type control fields. Also takes branch-taken and memory busy indications.
- Drives per-stage enable and bubble/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Holds a small stall FSM and saturating performance counters.

Parameters:
- LOAD_LATENCY, 1, number of bubble cycles inserted per load-use hazard (1..3).
- CNT_W, 16, width of the performance counters.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-low reset
- ID_RS1  in  5  ID-stage source register 1
- ID_RS2  in  5  ID-stage source register 2
- ID_USES_RS1  in  1  ID instruction reads RS1
- ID_USES_RS2  in  1  ID instruction reads RS2
- EX_RD  in  5  destination register of the instruction in EX (ID/EX output)
- EX_MEM_READ  in  3  ID/EX MEM_READ field; nonzero = load
- EX_REG_WRITE  in  1  ID/EX REG_WRITE field
- BRANCH_TAKEN  in  1  branch/jump resolved taken in EX
- DMEM_BUSY  in  1  data memory busy wait
- IMEM_BUSY  in  1  instruction memory busy wait
- PC_EN  out  1  PC update enable
- IFID_EN  out  1  IF/ID load enable
- IFID_FLUSH  out  1  IF/ID loads a NOP
- IDEX_EN  out  1  ID/EX load enable
- IDEX_BUBBLE  out  1  ID/EX loads all-zero control fields
- EXMEM_EN  out  1  EX/MEM load enable
- MEMWB_EN  out  1  MEM/WB load enable
- STATE  out  1  0 = RUN, 1 = LOAD_STALL
- STALL_COUNT  out  CNT_W  load-use bubble cycles
- FLUSH_COUNT  out  CNT_W  taken-branch flushes
- FREEZE_COUNT  out  CNT_W  DMEM_BUSY freeze cycles

Behaviour:
- Registered state: STATE, remaining-bubble counter REM (2 bits), and the three statistics counters. All control outputs are combinational from registered state and current inputs.
- Reset, sampled at posedge CLK with RESET==0: STATE=RUN, REM=0, all counters=0.
- While RESET==0, outputs are forced: all *_EN=0, IFID_FLUSH=1, IDEX_BUBBLE=1.
- Reset asserted mid-stall aborts the stall; no counter update occurs that edge.
- Load-use hazard: HAZ = (EX_MEM_READ!=0) & EX_REG_WRITE & (EX_RD!=0) & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
- Each cycle, the first matching row applies:
  1. DMEM_BUSY=1 (freeze): all *_EN=0, IFID_FLUSH=0, IDEX_BUBBLE=0. STATE and REM hold. FREEZE_COUNT+1.
  2. BRANCH_TAKEN=1: all *_EN=1, IFID_FLUSH=1, IDEX_BUBBLE=1. Next STATE=RUN, REM=0. FLUSH_COUNT+1. A pending load stall is discarded.
  3. STATE=RUN & HAZ: PC_EN=0, IFID_EN=0, IDEX_BUBBLE=1, other EN=1. STALL_COUNT+1. If LOAD_LATENCY==1, next STATE=RUN; else next STATE=LOAD_STALL, REM=LOAD_LATENCY-1.
  4. STATE=LOAD_STALL: same outputs as row 3. STALL_COUNT+1. REM decrements; when REM==1 before the edge, next STATE=RUN, REM=0.
  5. IMEM_BUSY=1: PC_EN=0, IFID_FLUSH=1, IFID_EN=1, rest EN=1, IDEX_BUBBLE=0. No counter change.
  6. Otherwise: all EN=1, IFID_FLUSH=0, IDEX_BUBBLE=0.
- HAZ is ignored while STATE=LOAD_STALL, because the ID/EX register holds a bubble.
- A write to x0 never stalls.
- Counters saturate at 2^CNT_W-1; no wrap.
- IFID_FLUSH and IDEX_BUBBLE are only asserted together with the matching EN=1, except under reset.

Test Plan:
- Reset: hold RESET=0 for 2 cycles, then release with no hazards. During reset, all EN=0, IFID_FLUSH=1, IDEX_BUBBLE=1; after release, all EN=1 and all counters = 0.
- LOAD_LATENCY=1: EX_MEM_READ=3'b010, EX_REG_WRITE=1, EX_RD=5, ID_RS2=5, ID_USES_RS2=1 -> exactly 1 cycle of PC_EN=0, IFID_EN=0, IDEX_BUBBLE=1, then RUN; STALL_COUNT=1. Repeat with EX_RD=0 -> no stall.
- LOAD_LATENCY=3, same hazard -> 3 consecutive bubble cycles with STATE=1 on cycles 2-3; STALL_COUNT=3.
- Freeze during stall: DMEM_BUSY=1 for 4 cycles inside the LOAD_STALL window -> all EN=0 for those 4 cycles, REM frozen, FREEZE_COUNT=4; the remaining bubbles resume afterwards.
- Precedence: BRANCH_TAKEN=1 together with HAZ, and IMEM_BUSY=1 -> IFID_FLUSH=1, IDEX_BUBBLE=1, PC_EN=1, FLUSH_COUNT+1, STALL_COUNT unchanged. IMEM_BUSY alone -> PC_EN=0, IFID_FLUSH=1.
- Saturation: CNT_W=4, 20 taken branches -> FLUSH_COUNT=15 and stays at 15.
